// File: rtl/rs_collapse_queue_pkg.sv
// rtl/rs_collapse_queue_pkg.sv - default widths and entry layout for the reservation station
package rs_collapse_queue_pkg;

   localparam int RS_DEPTH   = 4;
   localparam int RS_DATA_W  = 32;
   localparam int RS_TAG_W   = 5;
   localparam int RS_CTRL_W  = 9;
   localparam int RS_NUM_CDB = 4;

   // Packed entry layout (LSB first) as seen by dispatch and the ROB
   localparam int ENT_RDY_LSB  = 0;
   localparam int ENT_VAL_LSB  = ENT_RDY_LSB + 2;
   localparam int ENT_TAG_LSB  = ENT_VAL_LSB + 2*RS_DATA_W;
   localparam int ENT_DEST_LSB = ENT_TAG_LSB + 2*RS_TAG_W;
   localparam int ENT_CTRL_LSB = ENT_DEST_LSB + RS_TAG_W;
   localparam int ENT_W        = ENT_CTRL_LSB + RS_CTRL_W;

   typedef struct packed {
      logic [RS_CTRL_W-1:0]       ctrl;
      logic [RS_TAG_W-1:0]        dest;
      logic [1:0][RS_TAG_W-1:0]   tag;
      logic [1:0][RS_DATA_W-1:0]  val;
      logic [1:0]                 rdy;
   } rs_entry_t;

   function automatic logic [1:0] popcount2(input logic a, input logic b);
      return {a & b, a ^ b};
   endfunction

endpackage

// File: rtl/rs_collapse_queue_if.sv
// rtl/rs_collapse_queue_if.sv - dispatch, CDB and issue bundle of the reservation station
interface rs_collapse_queue_if
   import rs_collapse_queue_pkg::*;
#(
   parameter int DEPTH   = RS_DEPTH,
   parameter int DATA_W  = RS_DATA_W,
   parameter int TAG_W   = RS_TAG_W,
   parameter int CTRL_W  = RS_CTRL_W,
   parameter int NUM_CDB = RS_NUM_CDB
) ();
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic                       flush;
   logic                       alloc_valid;
   logic                       alloc_ready;
   logic [CTRL_W-1:0]          alloc_ctrl;
   logic [TAG_W-1:0]           alloc_dest;
   logic [1:0]                 alloc_src_rdy;
   logic [2*TAG_W-1:0]         alloc_src_tag;
   logic [2*DATA_W-1:0]        alloc_src_val;
   logic [NUM_CDB-1:0]         cdb_valid;
   logic [NUM_CDB*TAG_W-1:0]   cdb_tag;
   logic [NUM_CDB*DATA_W-1:0]  cdb_data;
   logic [1:0]                 iss_valid;
   logic [1:0]                 iss_ready;
   logic [2*DATA_W-1:0]        iss_op1;
   logic [2*DATA_W-1:0]        iss_op2;
   logic [2*TAG_W-1:0]         iss_dest;
   logic [2*CTRL_W-1:0]        iss_ctrl;
   logic [CNT_W-1:0]           count;
   logic                       empty;

   modport master (
      output flush, alloc_valid, alloc_ctrl, alloc_dest, alloc_src_rdy, alloc_src_tag,
             alloc_src_val, cdb_valid, cdb_tag, cdb_data, iss_ready,
      input  alloc_ready, iss_valid, iss_op1, iss_op2, iss_dest, iss_ctrl, count, empty
   );

   modport slave (
      input  flush, alloc_valid, alloc_ctrl, alloc_dest, alloc_src_rdy, alloc_src_tag,
             alloc_src_val, cdb_valid, cdb_tag, cdb_data, iss_ready,
      output alloc_ready, iss_valid, iss_op1, iss_op2, iss_dest, iss_ctrl, count, empty
   );

endinterface

// File: rtl/rs_collapse_queue_prio_enc.sv
// rtl/rs_collapse_queue_prio_enc.sv - lowest-index-first priority encoder
module rs_collapse_queue_prio_enc #(
   parameter int W = 4
) (
   input  logic [W-1:0]         req,
   output logic                 found,
   output logic [$clog2(W)-1:0] idx
);
   localparam int IDX_W = $clog2(W);

   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = W - 1; i >= 0; i--) begin
         if (req[i]) begin
            found = 1'b1;
            idx   = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/rs_collapse_queue.sv
// rtl/rs_collapse_queue.sv - age-ordered collapsing reservation station, dual issue
module rs_collapse_queue
   import rs_collapse_queue_pkg::*;
#(
   parameter int DEPTH   = RS_DEPTH,
   parameter int DATA_W  = RS_DATA_W,
   parameter int TAG_W   = RS_TAG_W,
   parameter int CTRL_W  = RS_CTRL_W,
   parameter int NUM_CDB = RS_NUM_CDB
) (
   input logic              clk,
   input logic              rst,
   rs_collapse_queue_if.slave bus
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int IDX_W = $clog2(DEPTH);

   logic [CTRL_W-1:0]         e_ctrl [DEPTH];
   logic [TAG_W-1:0]          e_dest [DEPTH];
   logic [1:0][TAG_W-1:0]     e_tag  [DEPTH];
   logic [1:0][DATA_W-1:0]    e_val  [DEPTH];
   logic [1:0]                e_rdy  [DEPTH];
   logic [CNT_W-1:0]          cnt;

   logic [DEPTH-1:0]          ready_vec, one_hot0, one_hot1, removed;
   logic [1:0]                pick_found;
   logic [IDX_W-1:0]          pick_idx [2];
   logic [1:0]                nrem;
   logic [1:0]                below  [DEPTH];
   logic [1:0][DATA_W-1:0]    w_val  [DEPTH];
   logic [1:0]                w_rdy  [DEPTH];
   logic [1:0][DATA_W-1:0]    a_val;
   logic [1:0]                a_rdy;
   logic [IDX_W-1:0]          src_idx [DEPTH];
   logic [DEPTH-1:0]          src_ok;
   logic                      alloc_fire;
   logic [CNT_W-1:0]          alloc_slot;

   always_comb begin
      for (int i = 0; i < DEPTH; i++)
         ready_vec[i] = (CNT_W'(i) < cnt) && (e_rdy[i] == 2'b11);
   end

   rs_collapse_queue_prio_enc #(.W(DEPTH)) u_pick0 (
      .req   (ready_vec),
      .found (pick_found[0]),
      .idx   (pick_idx[0])
   );

   rs_collapse_queue_prio_enc #(.W(DEPTH)) u_pick1 (
      .req   (ready_vec & ~one_hot0),
      .found (pick_found[1]),
      .idx   (pick_idx[1])
   );

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         one_hot0[i] = pick_found[0] && (pick_idx[0] == IDX_W'(i));
         one_hot1[i] = pick_found[1] && (pick_idx[1] == IDX_W'(i));
         removed[i]  = (one_hot0[i] && bus.iss_ready[0]) || (one_hot1[i] && bus.iss_ready[1]);
      end
      nrem = popcount2(pick_found[0] && bus.iss_ready[0], pick_found[1] && bus.iss_ready[1]);
   end

   always_comb begin
      bus.iss_valid = pick_found;
      bus.iss_op1   = '0;
      bus.iss_op2   = '0;
      bus.iss_dest  = '0;
      bus.iss_ctrl  = '0;
      for (int p = 0; p < 2; p++) begin
         if (pick_found[p]) begin
            bus.iss_op1[p*DATA_W +: DATA_W] = e_val[pick_idx[p]][0];
            bus.iss_op2[p*DATA_W +: DATA_W] = e_val[pick_idx[p]][1];
            bus.iss_dest[p*TAG_W +: TAG_W]  = e_dest[pick_idx[p]];
            bus.iss_ctrl[p*CTRL_W +: CTRL_W] = e_ctrl[pick_idx[p]];
         end
      end
   end

   // Wakeup: scan channels high to low so the lowest matching channel wins
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         for (int k = 0; k < 2; k++) begin
            w_val[i][k] = e_val[i][k];
            w_rdy[i][k] = e_rdy[i][k];
            if (!e_rdy[i][k]) begin
               for (int c = NUM_CDB - 1; c >= 0; c--) begin
                  if (bus.cdb_valid[c] && (bus.cdb_tag[c*TAG_W +: TAG_W] == e_tag[i][k])) begin
                     w_val[i][k] = bus.cdb_data[c*DATA_W +: DATA_W];
                     w_rdy[i][k] = 1'b1;
                  end
               end
            end
         end
      end
   end

   always_comb begin
      for (int k = 0; k < 2; k++) begin
         a_val[k] = bus.alloc_src_val[k*DATA_W +: DATA_W];
         a_rdy[k] = bus.alloc_src_rdy[k];
         if (!bus.alloc_src_rdy[k]) begin
            for (int c = NUM_CDB - 1; c >= 0; c--) begin
               if (bus.cdb_valid[c] &&
                   (bus.cdb_tag[c*TAG_W +: TAG_W] == bus.alloc_src_tag[k*TAG_W +: TAG_W])) begin
                  a_val[k] = bus.cdb_data[c*DATA_W +: DATA_W];
                  a_rdy[k] = 1'b1;
               end
            end
         end
      end
   end

   // Collapse: survivor i lands in slot i - (removed slots below i)
   always_comb begin
      logic [1:0] acc;
      acc = 2'd0;
      for (int i = 0; i < DEPTH; i++) begin
         below[i] = acc;
         acc      = acc + {1'b0, removed[i]};
      end
      for (int j = 0; j < DEPTH; j++) begin
         src_ok[j]  = 1'b0;
         src_idx[j] = '0;
         for (int i = 0; i < DEPTH; i++) begin
            if (!removed[i] && (CNT_W'(i) < cnt) && ((i - int'(below[i])) == j)) begin
               src_ok[j]  = 1'b1;
               src_idx[j] = IDX_W'(i);
            end
         end
      end
   end

   assign alloc_fire      = bus.alloc_valid && bus.alloc_ready;
   assign alloc_slot      = cnt - CNT_W'(nrem);
   assign bus.alloc_ready = (cnt < CNT_W'(DEPTH));
   assign bus.count       = cnt;
   assign bus.empty       = (cnt == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         for (int j = 0; j < DEPTH; j++) begin
            e_ctrl[j] <= '0;
            e_dest[j] <= '0;
            e_tag[j]  <= '0;
            e_val[j]  <= '0;
            e_rdy[j]  <= 2'b00;
         end
      end else if (bus.flush) begin
         cnt <= '0;
         for (int j = 0; j < DEPTH; j++)
            e_rdy[j] <= 2'b00;
      end else begin
         cnt <= cnt - CNT_W'(nrem) + CNT_W'(alloc_fire);
         for (int j = 0; j < DEPTH; j++) begin
            if (src_ok[j]) begin
               e_ctrl[j] <= e_ctrl[src_idx[j]];
               e_dest[j] <= e_dest[src_idx[j]];
               e_tag[j]  <= e_tag[src_idx[j]];
               e_val[j]  <= w_val[src_idx[j]];
               e_rdy[j]  <= w_rdy[src_idx[j]];
            end else if (alloc_fire && (alloc_slot == CNT_W'(j))) begin
               e_ctrl[j] <= bus.alloc_ctrl;
               e_dest[j] <= bus.alloc_dest;
               e_tag[j]  <= bus.alloc_src_tag;
               e_val[j]  <= a_val;
               e_rdy[j]  <= a_rdy;
            end else begin
               e_rdy[j]  <= 2'b00;
            end
         end
      end
   end

endmodule

// File: tb/tb_rs_collapse_queue.sv
// tb/tb_rs_collapse_queue.sv - randomized and directed bench against a queue model
module tb_rs_collapse_queue;
   localparam int DEPTH = 4, DATA_W = 32, TAG_W = 5, CTRL_W = 9, NUM_CDB = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rs_collapse_queue_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W),
                          .CTRL_W(CTRL_W), .NUM_CDB(NUM_CDB)) rsif ();

   rs_collapse_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W),
                       .CTRL_W(CTRL_W), .NUM_CDB(NUM_CDB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (rsif)
   );

   typedef struct {
      logic [CTRL_W-1:0]       ctrl;
      logic [TAG_W-1:0]        dest;
      logic [1:0][TAG_W-1:0]   tag;
      logic [1:0][DATA_W-1:0]  val;
      logic [1:0]              rdy;
   } ent_t;

   ent_t mq[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic void picks(output int p0, output int p1);
      p0 = -1;
      p1 = -1;
      foreach (mq[i]) begin
         if (mq[i].rdy == 2'b11) begin
            if (p0 < 0)      p0 = i;
            else if (p1 < 0) p1 = i;
         end
      end
   endfunction

   task automatic model_check();
      int p[2];
      logic [1:0]          ev;
      logic [63:0]         eop1, eop2;
      logic [2*TAG_W-1:0]  edest;
      logic [2*CTRL_W-1:0] ectrl;
      picks(p[0], p[1]);
      ev = 0; eop1 = 0; eop2 = 0; edest = 0; ectrl = 0;
      for (int pp = 0; pp < 2; pp++) begin
         if (p[pp] >= 0) begin
            ev[pp] = 1'b1;
            eop1[pp*DATA_W +: DATA_W]  = mq[p[pp]].val[0];
            eop2[pp*DATA_W +: DATA_W]  = mq[p[pp]].val[1];
            edest[pp*TAG_W +: TAG_W]   = mq[p[pp]].dest;
            ectrl[pp*CTRL_W +: CTRL_W] = mq[p[pp]].ctrl;
         end
      end
      chk("iss_valid", 64'(rsif.iss_valid), 64'(ev));
      chk("iss_op1", rsif.iss_op1, eop1);
      chk("iss_op2", rsif.iss_op2, eop2);
      chk("iss_dest", 64'(rsif.iss_dest), 64'(edest));
      chk("iss_ctrl", 64'(rsif.iss_ctrl), 64'(ectrl));
      chk("count", 64'(rsif.count), 64'(mq.size()));
      chk("empty", 64'(rsif.empty), 64'(mq.size() == 0));
      chk("alloc_ready", 64'(rsif.alloc_ready), 64'(mq.size() < DEPTH));
   endtask

   task automatic model_update();
      int   p0, p1, sz;
      ent_t e;
      logic hit;
      if (rst || rsif.flush) begin
         mq.delete();
         return;
      end
      sz = mq.size();
      picks(p0, p1);
      foreach (mq[i]) begin
         e = mq[i];
         for (int k = 0; k < 2; k++) begin
            hit = 1'b0;
            for (int c = 0; c < NUM_CDB; c++) begin
               if (!e.rdy[k] && !hit && rsif.cdb_valid[c] &&
                   rsif.cdb_tag[c*TAG_W +: TAG_W] == e.tag[k]) begin
                  e.val[k] = rsif.cdb_data[c*DATA_W +: DATA_W];
                  e.rdy[k] = 1'b1;
                  hit = 1'b1;
               end
            end
         end
         mq[i] = e;
      end
      if (p1 >= 0 && rsif.iss_ready[1]) mq.delete(p1);
      if (p0 >= 0 && rsif.iss_ready[0]) mq.delete(p0);
      if (rsif.alloc_valid && sz < DEPTH) begin
         e.ctrl = rsif.alloc_ctrl;
         e.dest = rsif.alloc_dest;
         for (int k = 0; k < 2; k++) begin
            e.tag[k] = rsif.alloc_src_tag[k*TAG_W +: TAG_W];
            e.val[k] = rsif.alloc_src_val[k*DATA_W +: DATA_W];
            e.rdy[k] = rsif.alloc_src_rdy[k];
            hit = 1'b0;
            for (int c = 0; c < NUM_CDB; c++) begin
               if (!e.rdy[k] && !hit && rsif.cdb_valid[c] &&
                   rsif.cdb_tag[c*TAG_W +: TAG_W] == e.tag[k]) begin
                  e.val[k] = rsif.cdb_data[c*DATA_W +: DATA_W];
                  e.rdy[k] = 1'b1;
                  hit = 1'b1;
               end
            end
         end
         mq.push_back(e);
      end
   endtask

   task automatic step();
      #1;
      model_check();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic idle();
      rsif.flush = 0; rsif.alloc_valid = 0; rsif.alloc_ctrl = 0; rsif.alloc_dest = 0;
      rsif.alloc_src_rdy = 0; rsif.alloc_src_tag = 0; rsif.alloc_src_val = 0;
      rsif.cdb_valid = 0; rsif.cdb_tag = 0; rsif.cdb_data = 0;
   endtask

   task automatic set_alloc(input int ctrl, input int dest, input logic [1:0] rdy,
                            input int tag1, input int tag0, input int val1, input int val0);
      rsif.alloc_valid   = 1'b1;
      rsif.alloc_ctrl    = CTRL_W'(ctrl);
      rsif.alloc_dest    = TAG_W'(dest);
      rsif.alloc_src_rdy = rdy;
      rsif.alloc_src_tag = {TAG_W'(tag1), TAG_W'(tag0)};
      rsif.alloc_src_val = {DATA_W'(val1), DATA_W'(val0)};
   endtask

   task automatic set_cdb(input int c, input int tag, input int data);
      rsif.cdb_valid[c] = 1'b1;
      rsif.cdb_tag[c*TAG_W +: TAG_W] = TAG_W'(tag);
      rsif.cdb_data[c*DATA_W +: DATA_W] = DATA_W'(data);
   endtask

   initial begin
      idle();
      rsif.iss_ready = 2'b00;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      mq.delete();

      chk("rst_alloc_ready", 64'(rsif.alloc_ready), 64'd1);
      chk("rst_iss_valid", 64'(rsif.iss_valid), 64'd0);
      chk("rst_iss_op1", rsif.iss_op1, 64'd0);
      chk("rst_iss_dest", 64'(rsif.iss_dest), 64'd0);
      chk("rst_count", 64'(rsif.count), 64'd0);
      chk("rst_empty", 64'(rsif.empty), 64'd1);

      // Four ready ops, then drain in pairs
      for (int d = 1; d <= 4; d++) begin
         set_alloc(d * 3, d, 2'b11, 0, 0, d * 200, d * 100);
         step();
         if (d == 1) chk("t1_first_dest", 64'(rsif.iss_dest[TAG_W-1:0]), 64'd1);
      end
      idle();
      chk("t1_full_count", 64'(rsif.count), 64'd4);
      chk("t1_full_ready", 64'(rsif.alloc_ready), 64'd0);
      rsif.iss_ready = 2'b11;
      chk("t1_pair12", 64'(rsif.iss_dest), 64'({TAG_W'(2), TAG_W'(1)}));
      step();
      chk("t1_pair34", 64'(rsif.iss_dest), 64'({TAG_W'(4), TAG_W'(3)}));
      step();
      chk("t1_drained", 64'(rsif.empty), 64'd1);

      // Waiting op bypassed by younger ready ops, then woken by CDB ch2
      rsif.iss_ready = 2'b00;
      set_alloc(1, 10, 2'b10, 0, 7, 32'hB0, 0); step();
      set_alloc(2, 11, 2'b11, 0, 0, 1, 2);     step();
      set_alloc(3, 12, 2'b11, 0, 0, 3, 4);     step();
      idle();
      set_cdb(2, 7, 32'hDEAD);
      rsif.iss_ready = 2'b11;
      chk("t2_bc_first", 64'(rsif.iss_dest), 64'({TAG_W'(12), TAG_W'(11)}));
      step();
      idle();
      chk("t2_a_valid", 64'(rsif.iss_valid), 64'd1);
      chk("t2_a_op1", 64'(rsif.iss_op1[DATA_W-1:0]), 64'hDEAD);
      step();

      // Allocation bypass from CDB ch0
      rsif.iss_ready = 2'b00;
      set_alloc(5, 20, 2'b01, 9, 0, 0, 1);
      set_cdb(0, 9, 32'h55);
      step();
      idle();
      chk("t3_valid", 64'(rsif.iss_valid), 64'd1);
      chk("t3_op2", 64'(rsif.iss_op2[DATA_W-1:0]), 64'h55);
      rsif.iss_ready = 2'b11;
      step();

      // Full with port 0 stalled: port 1 removes second-oldest, alloc refused
      rsif.iss_ready = 2'b00;
      for (int d = 31; d <= 34; d++) begin
         set_alloc(d, d, 2'b11, 0, 0, d, d);
         step();
      end
      set_alloc(35, 35, 2'b11, 0, 0, 35, 35);
      rsif.iss_ready = 2'b10;
      chk("t4_full_ready", 64'(rsif.alloc_ready), 64'd0);
      step();
      idle();
      chk("t4_count", 64'(rsif.count), 64'd3);
      chk("t4_ready_again", 64'(rsif.alloc_ready), 64'd1);
      chk("t4_order", 64'(rsif.iss_dest), 64'({TAG_W'(33), TAG_W'(31)}));
      rsif.iss_ready = 2'b11;
      step();
      chk("t4_last", 64'(rsif.iss_dest), 64'(TAG_W'(34)));
      step();

      // Two channels match: lowest channel wins
      rsif.iss_ready = 2'b00;
      set_alloc(7, 40, 2'b10, 0, 3, 9, 0);
      step();
      idle();
      set_cdb(1, 3, 32'h11);
      set_cdb(3, 3, 32'h22);
      step();
      idle();
      chk("t5_lowest_ch", 64'(rsif.iss_op1[DATA_W-1:0]), 64'h11);
      rsif.iss_ready = 2'b11;
      step();

      // Flush overrides alloc, issue and wakeup
      rsif.iss_ready = 2'b00;
      for (int d = 45; d <= 47; d++) begin
         set_alloc(d, d, 2'b11, 0, 0, d, d);
         step();
      end
      set_alloc(50, 50, 2'b11, 0, 0, 50, 50);
      set_cdb(0, 1, 1);
      rsif.flush = 1'b1;
      rsif.iss_ready = 2'b11;
      step();
      idle();
      chk("t6_count", 64'(rsif.count), 64'd0);
      chk("t6_iss_valid", 64'(rsif.iss_valid), 64'd0);
      step();

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         rsif.alloc_valid   = ($urandom % 10) < 6;
         rsif.alloc_ctrl    = CTRL_W'($urandom);
         rsif.alloc_dest    = TAG_W'($urandom);
         rsif.alloc_src_rdy = 2'($urandom);
         rsif.alloc_src_tag = {TAG_W'($urandom_range(0, 7)), TAG_W'($urandom_range(0, 7))};
         rsif.alloc_src_val = {DATA_W'($urandom), DATA_W'($urandom)};
         rsif.cdb_valid     = NUM_CDB'($urandom);
         for (int c = 0; c < NUM_CDB; c++) begin
            rsif.cdb_tag[c*TAG_W +: TAG_W]    = TAG_W'($urandom_range(0, 7));
            rsif.cdb_data[c*DATA_W +: DATA_W] = DATA_W'($urandom);
         end
         rsif.iss_ready = 2'($urandom);
         rsif.flush     = ($urandom % 50) == 0;
         rst            = ($urandom % 200) == 0;
         step();
      end
      rst = 1'b0;
      idle();
      rsif.iss_ready = 2'b11;
      repeat (4) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rs_collapse_queue.md
# rs_collapse_queue

Parametrised, age-ordered reservation station for the out-of-order core. It sits between rename/dispatch and the ALU/load pipes. It holds up to DEPTH instructions with operand values or pending tags, and captures results from NUM_CDB broadcast channels. Each cycle it issues the oldest ready instructions on up to two ports using a valid/ready handshake. Entries are kept in allocation order in a collapsing array, which adds oldest-first selection, downstream stall, same-cycle wakeup capture and flush.

## Interface
Parameters:
- DEPTH, 4: entry count (≥2)
- DATA_W, 32: operand width
- TAG_W, 5: physical/ROB tag width
- CTRL_W, 9: control word width
- NUM_CDB, 4: broadcast channels (2 ALU + 2 load in current core)

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous invalidate-all (mispredict)
- alloc_valid  in  1  dispatch offers an instruction
- alloc_ready  out  1  = (count < DEPTH)
- alloc_ctrl  in  CTRL_W  control word
- alloc_dest  in  TAG_W  destination tag
- alloc_src_rdy  in  2  [0]=op1 value valid, [1]=op2 value valid
- alloc_src_tag  in  2*TAG_W  {op2 tag, op1 tag}
- alloc_src_val  in  2*DATA_W  {op2, op1}
- cdb_valid  in  NUM_CDB  per-channel broadcast valid
- cdb_tag  in  NUM_CDB*TAG_W  channel c at [c*TAG_W +: TAG_W]
- cdb_data  in  NUM_CDB*DATA_W  channel c at [c*DATA_W +: DATA_W]
- iss_valid  out  2  per-port issue valid
- iss_ready  in  2  per-port accept
- iss_op1, iss_op2  out  2*DATA_W each  port p at [p*DATA_W +: DATA_W]
- iss_dest  out  2*TAG_W  issuing destination tags
- iss_ctrl  out  2*CTRL_W  issuing control words
- count  out  $clog2(DEPTH+1)  occupied entries
- empty  out  1  count==0

## Operation
- Entries occupy slots 0..count-1. Slot 0 is the oldest. Entry fields: ctrl, dest, tag[2], val[2], rdy[2].
- Ready vector: rdy[i]==2'b11 for i<count.
  - Port 0 selects the lowest ready index.
  - Port 1 selects the next lowest ready index after masking port 0's pick.
  - iss_valid[p] is set iff port p has a pick.
- Data outputs are combinational from registered state and are zero when iss_valid[p]=0.
- Removal: an entry is removed iff iss_valid[p]&&iss_ready[p] for its port. Ports are independent: a stalled port 0 does not block port 1.
- Collapse: surviving entries shift down, preserving order, in the same edge. Removals may be 0, 1 or 2, and non-adjacent.
- Allocation: on alloc_valid&&alloc_ready the new entry is written at slot (count − removals_this_cycle).
  - count_next = count + alloc − removals.
  - alloc_ready does not credit same-cycle removals.
- Wakeup: for each valid entry and each operand with rdy=0, a CDB channel with cdb_valid and matching tag writes val and sets rdy. If several channels match, the lowest channel index wins. Operands already ready are never overwritten.
- Allocation bypass: an incoming operand with alloc_src_rdy=0 whose tag matches a valid CDB channel in the same cycle is stored ready with the CDB data.
- Wakeup applies to entries whether or not they shift this cycle.
- Flush: clears count and all rdy bits. It overrides alloc, issue removal and wakeup in that cycle. The issue handshake in a flush cycle is ignored by the RS (downstream discards).
- Reset: identical effect to flush; stored values are cleared to 0.

## Timing
- Reset values: alloc_ready=1, iss_valid=2'b00, iss_op*/iss_dest/iss_ctrl=0, count=0, empty=1.
- Alloc with both operands ready at edge N: iss_valid may assert after edge N (cycle N+1).
- CDB broadcast in cycle N: the dependent entry may issue in cycle N+1. There is no same-cycle CDB→issue forward.
- Full, with one issue and one alloc in the same cycle: alloc is refused (alloc_ready=0). count drops to DEPTH−1 and alloc_ready=1 next cycle.
- Issue is throughput 2/cycle with zero-cycle handshake latency. No internal state machine beyond the collapsing array.

## Structure
- rs_pkg holds default widths and the localparam entry bit-layout offsets shared with the dispatch and ROB blocks.
- Reuse the existing priority_encoder sub-module, parameterised to DEPTH, instantiated twice (second on the masked vector).
- Collapse computes a per-slot source index via a prefix count of removed slots below each slot; this is generate-loop logic, not a sub-module.

## Test plan
- Reset, then alloc 4 ready ops (dest 1..4), iss_ready=11 → cycle after first alloc iss_dest port0=1; ports issue {1,2} then {3,4}; count returns to 0, empty=1.
- Alloc A (op1 waits tag 7), B ready, C ready; CDB ch2 tag 7 data 0xDEAD next cycle → B,C issue first; A issues the cycle after the broadcast with op1=0xDEAD.
- Alloc with op2 tag 9 while cdb_valid[0] tag 9 data 0x55 in the same cycle → entry issues next cycle with op2=0x55.
- Fill to DEPTH, iss_ready=2'b10 (port 0 stalled) → port 1 removes second-oldest only; slot order is preserved; alloc_ready=0 during the full cycle.
- Two CDB channels with the same tag 3, data 0x11 (ch1) and 0x22 (ch3) → captured value 0x11.
- Flush asserted with alloc_valid and iss handshake active, DEPTH−1 entries → next cycle count=0, iss_valid=00, new entry not written.
